// File: rtl/edge_counter_n_bit.sv
// Width-generic edge counter: synchronised rising edges of count_in step an up/down
// counter with programmable modulus, wrap/saturate, preset, carry/borrow and a capture register.
module edge_counter_n_bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             count_in,
    input  logic             enable,
    input  logic             direction,
    input  logic             saturate,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] count_held,
    output logic             carry,
    output logic             borrow,
    output logic             zero
);

    logic             s1, s2, prev;
    logic             edge_det;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] count_nxt;
    logic             carry_nxt, borrow_nxt;

    // All three stages load the raw input in reset so a level held across release is not an edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1   <= count_in;
            s2   <= count_in;
            prev <= count_in;
        end else begin
            s1   <= count_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign edge_det = s2 & ~prev;
    assign top_val  = (limit == '0) ? '1 : limit - 1'b1;

    always_comb begin
        count_nxt  = count_out;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (load) begin
            count_nxt = (load_value > top_val) ? top_val : load_value;
        end else if (edge_det && enable) begin
            if (direction) begin
                if (count_out < top_val) begin
                    count_nxt = count_out + 1'b1;
                end else begin
                    carry_nxt = 1'b1;
                    count_nxt = saturate ? top_val : '0;
                end
            end else begin
                if (count_out == '0) begin
                    borrow_nxt = 1'b1;
                    count_nxt  = saturate ? '0 : top_val;
                end else if (count_out > top_val) begin
                    // Limit was lowered under a live count: snap to the new bound silently.
                    count_nxt = top_val;
                end else begin
                    count_nxt = count_out - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_out  <= '0;
            count_held <= '0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
        end else begin
            count_out <= count_nxt;
            carry     <= carry_nxt;
            borrow    <= borrow_nxt;
            if (!hold)
                count_held <= count_out;
        end
    end

    assign zero = (count_out == '0);

endmodule

// File: tb/tb_edge_counter_n_bit.sv
// Self-checking bench for edge_counter_n_bit: reference model compared every cycle,
// a load/reset vector table, directed multi-cycle scenarios and a randomized phase.
module tb_edge_counter_n_bit;

    localparam int WIDTH = 8;
    localparam int FULL  = (1 << WIDTH) - 1;

    logic             clk_in = 1'b0;
    logic             reset = 1'b0, count_in = 1'b0, enable = 1'b1, direction = 1'b1;
    logic             saturate = 1'b0, load = 1'b0, hold = 1'b0;
    logic [WIDTH-1:0] limit = '0, load_value = '0;
    logic [WIDTH-1:0] count_out, count_held;
    logic             carry, borrow, zero;

    edge_counter_n_bit #(.WIDTH(WIDTH)) dut (
        .clk_in(clk_in), .reset(reset), .count_in(count_in), .enable(enable),
        .direction(direction), .saturate(saturate), .limit(limit), .load(load),
        .load_value(load_value), .hold(hold), .count_out(count_out),
        .count_held(count_held), .carry(carry), .borrow(borrow), .zero(zero)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0, n_fail = 0;
    int carry_seen = 0, borrow_seen = 0;

    // Model state: count as a plain integer; h1..h3 are count_in as sampled 1..3 clocks ago.
    bit model_ok = 0;
    int m_cnt = 0, m_held = 0;
    bit m_carry = 0, m_borrow = 0;
    bit h1 = 0, h2 = 0, h3 = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int top;
        bit ev;
        top = (limit == 0) ? FULL : int'(limit) - 1;
        if (reset) begin
            m_cnt = 0; m_held = 0; m_carry = 0; m_borrow = 0;
            h1 = count_in; h2 = count_in; h3 = count_in;
            model_ok = 1;
        end else begin
            ev = h2 && !h3;
            if (!hold) m_held = m_cnt;
            m_carry = 0; m_borrow = 0;
            if (load) begin
                m_cnt = (int'(load_value) > top) ? top : int'(load_value);
            end else if (ev && enable) begin
                if (direction) begin
                    if (m_cnt < top) m_cnt++;
                    else begin m_carry = 1; m_cnt = saturate ? top : 0; end
                end else begin
                    if (m_cnt == 0) begin m_borrow = 1; m_cnt = saturate ? 0 : top; end
                    else if (m_cnt > top) m_cnt = top;
                    else m_cnt--;
                end
            end
            h3 = h2; h2 = h1; h1 = count_in;
        end
    endtask

    // Inputs are stable between negedges; predict, clock, then compare on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        if (carry)  carry_seen++;
        if (borrow) borrow_seen++;
        if (model_ok) begin
            check("model count_out", count_out, m_cnt);
            check("model count_held", count_held, m_held);
            check("model carry", carry, m_carry);
            check("model borrow", borrow, m_borrow);
            check("model zero", zero, (m_cnt == 0));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        count_in = 1'b1; ticks(hi);
        count_in = 1'b0; ticks(lo);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    typedef struct {
        logic             rst;
        logic             ld;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] lim;
        int               exp_cnt;
        logic             exp_zero;
    } vec_t;

    vec_t tbl[7];

    int exp_up[12];
    int exp_dn[4];
    int c0, b0;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd0,   8'd10, 0,   1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'd200, 8'd10, 9,   1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'd3,   8'd10, 3,   1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'd0,   8'd10, 0,   1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'd255, 8'd0,  255, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'd9,   8'd10, 9,   1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'd7,   8'd10, 0,   1'b1};
        for (int i = 0; i < 12; i++) exp_up[i] = (i + 1) % 10;
        exp_dn = '{1, 0, 0, 0};

        @(negedge clk_in);
        do_reset();
        check("reset count_out", count_out, 0);
        check("reset count_held", count_held, 0);
        check("reset zero", zero, 1);
        check("reset carry", carry, 0);

        // Load/reset vector table, count_in idle
        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst; load = tbl[i].ld; load_value = tbl[i].lv; limit = tbl[i].lim;
            tick();
            check("vec count_out", count_out, tbl[i].exp_cnt);
            check("vec zero", zero, tbl[i].exp_zero);
            check("vec carry", carry, 0);
            check("vec borrow", borrow, 0);
        end
        reset = 0; load = 0;

        // Basic up, wrap, with explicit 2-clock latency on the first event
        limit = 10; direction = 1; saturate = 0; do_reset();
        c0 = carry_seen;
        count_in = 1; ticks(2);
        check("latency before N+2", count_out, 0);
        tick();
        check("latency at N+2", count_out, 1);
        ticks(1); count_in = 0; ticks(4);
        for (int i = 1; i < 12; i++) begin
            pulse(4, 4);
            check("up wrap count", count_out, exp_up[i]);
        end
        check("up wrap carry pulses", carry_seen - c0, 1);

        // Down, saturate, full range
        limit = 0; direction = 0; saturate = 1;
        load = 1; load_value = 2; tick(); load = 0;
        b0 = borrow_seen;
        for (int i = 0; i < 4; i++) begin
            pulse(4, 4);
            check("down sat count", count_out, exp_dn[i]);
            if (i >= 1) check("down sat zero", zero, 1);
        end
        check("down sat borrow pulses", borrow_seen - b0, 2);

        // Load clamp colliding with a detected edge
        limit = 10; direction = 1; saturate = 0; do_reset();
        c0 = carry_seen;
        count_in = 1; ticks(2);
        load = 1; load_value = 200; tick(); load = 0;
        check("load clamp", count_out, 9);
        check("load collide carry", carry, 0);
        ticks(4); count_in = 0; ticks(4);
        check("load edge discarded", count_out, 9);
        check("load no carry", carry_seen - c0, 0);

        // Reset with count_in high across release, then reset mid-count
        count_in = 1; do_reset(); ticks(10);
        check("reset level not counted", count_out, 0);
        count_in = 0; ticks(4);
        for (int i = 0; i < 5; i++) pulse(3, 3);
        check("pre-reset count", count_out, 5);
        do_reset();
        check("mid-count reset", count_out, 0);

        // Enable gating and hold
        enable = 0; for (int i = 0; i < 3; i++) pulse(3, 3);
        check("enable off", count_out, 0);
        enable = 1; for (int i = 0; i < 2; i++) pulse(3, 3);
        check("enable on", count_out, 2);
        pulse(3, 3);
        check("count three", count_out, 3);
        hold = 1; for (int i = 0; i < 2; i++) pulse(3, 3);
        check("hold count_out", count_out, 5);
        check("hold count_held", count_held, 3);
        hold = 0; tick();
        check("hold release", count_held, 5);

        // Runtime limit drop, up then down
        limit = 10; load = 1; load_value = 8; tick(); load = 0;
        limit = 5; direction = 1; c0 = carry_seen;
        pulse(4, 4);
        check("limit drop up", count_out, 0);
        check("limit drop carry", carry_seen - c0, 1);
        limit = 10; load = 1; load_value = 8; tick(); load = 0;
        limit = 5; direction = 0; b0 = borrow_seen;
        pulse(4, 4);
        check("limit drop down", count_out, 4);
        check("limit drop no borrow", borrow_seen - b0, 0);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            count_in   = ($urandom_range(0, 2) == 0) ? ~count_in : count_in;
            enable     = ($urandom_range(0, 7) != 0);
            direction  = $urandom_range(0, 1);
            saturate   = $urandom_range(0, 1);
            hold       = ($urandom_range(0, 3) == 0);
            load       = ($urandom_range(0, 30) == 0);
            load_value = WIDTH'($urandom);
            reset      = ($urandom_range(0, 200) == 0);
            if ($urandom_range(0, 40) == 0)
                limit = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 12));
            tick();
        end
        reset = 0; load = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_counter_n_bit.md
# edge_counter_n_bit

- Parametrised synchronous edge counter. It counts rising edges of an asynchronous or slow `count_in` signal, sampled on the fast system clock `clk_in`.
- Features: width-generic, up/down, programmable modulus, wrap or saturate mode, synchronous preset, carry/borrow pulses, and a hold-able capture register.
- Successor to the fixed 8-bit synchro counters and the 16-bit latch; used for timebases, event tallies and address sequencing.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; legal 2..30.

Ports:
- `clk_in`  in  1: system clock; all state changes on rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `count_in`  in  1: asynchronous count source; each rising edge is one count event.
- `enable`  in  1: 1 = act on detected edges; 0 = drop them (edge detector still tracks).
- `direction`  in  1: 1 = up, 0 = down; sampled in the update cycle.
- `saturate`  in  1: 0 = wrap at bounds, 1 = stick at bounds.
- `limit`  in  WIDTH: modulus; `top = limit-1`; `limit==0` gives `top = 2^WIDTH-1`.
- `load`  in  1: synchronous preset strobe.
- `load_value`  in  WIDTH: preset value.
- `hold`  in  1: 1 freezes `count_held`.
- `count_out`  out  WIDTH: live count, registered.
- `count_held`  out  WIDTH: captured count, registered.
- `carry`  out  1: one-cycle pulse when an up-count hits the upper bound.
- `borrow`  out  1: one-cycle pulse when a down-count hits the lower bound.
- `zero`  out  1: `count_out == 0`; decoded from the register, no extra latency.

## Operation
- **Synchroniser:** 2-flop synchroniser `s1`→`s2`, plus `prev`.
  - `edge = s2 & !prev`.
  - During reset, `s1`, `s2` and `prev` all load `count_in`, so a level held across reset release is never counted.
- **Priority per cycle:** `reset` > `load` > `(edge & enable)` > idle.
- **Reset:** `count_out=0`, `count_held=0`, `carry=0`, `borrow=0`; `zero` reads 1.
- **Load:**
  - `count_out <= (load_value > top) ? top : load_value`.
  - `carry` and `borrow` are 0 in the following cycle.
  - An edge coinciding with `load` is discarded.
- **Up-count on edge:**
  - `count < top`: count+1.
  - `count >= top`: `carry` pulses; count becomes 0 (wrap) or `top` (saturate).
- **Down-count on edge:**
  - `0 < count <= top`: count-1.
  - `count == 0`: `borrow` pulses; count becomes `top` (wrap) or 0 (saturate).
  - `count > top` (limit lowered at runtime): count becomes `top`, no `borrow`.
- **Flags:** `carry`/`borrow` are registered and high for exactly one cycle per triggering edge; otherwise 0.
- **Saturate mode:** `carry`/`borrow` pulse on every edge at the bound.
- **Full range (`limit==0`):** arithmetic is modulo `2^WIDTH`; no intermediate wider than WIDTH+1 bits.
- **Capture:** `count_held <= count_out` every cycle while `hold==0`; it retains its value while `hold==1`. It is updated by `reset` regardless of `hold`.
- **`enable==0`:** edges are consumed by the detector and lost; they are not queued.

## Timing
- `count_in` rises and is sampled at edge N. `s2` is 1 after N+1. `count_out`, `carry` and `borrow` update at edge N+2 (2-cycle latency).
- `count_held` lags `count_out` by one further cycle (edge N+3).
- `load` asserted at edge M gives `count_out` valid after M.
- `reset` asserted at edge R: all outputs at reset value after R.
- Maximum count rate: one event per 2 `clk_in` cycles. `count_in` high and low phases must each be ≥ 2 `clk_in` periods to guarantee counting.
- `direction`, `saturate`, `limit` and `enable` take effect on the cycle they are sampled; no pipelining of controls.

## Test plan
- **Basic up, wrap:** WIDTH=8, limit=10, up, wrap, 12 `count_in` pulses (4 clk high / 4 low). Required: `count_out` 1..9,0,1,2; one `carry` pulse on the 9→0 update; each update 2 clocks after the sampled rise.
- **Down, saturate:** limit=0, down, saturate, load 2, 4 pulses. Required: 1, 0, 0, 0; `borrow` pulses on the 3rd and 4th events; `zero`=1 from the 2nd event.
- **Load clamp and collision:** limit=10, `load_value`=200 together with a detected edge. Required: `count_out`=9, no increment, `carry`=0.
- **Reset behaviour:** `count_in` held high through reset release, then steady for 10 clocks. Required: `count_out`=0, no edge counted; reset mid-count (value 5) gives 0 on the next clock.
- **Enable and hold:** `enable`=0 for 3 pulses, then 1 for 2 pulses. Required: count +2 only. With `hold`=1 after count=3, further counts leave `count_held`=3; releasing `hold` gives `count_held` = `count_out` one clock later.
- **Runtime limit drop:** count=8, limit changed 10→5. Next up edge gives 0 with `carry`; alternatively, next down edge gives 4 with no `borrow`.
